// File: rtl/tl_pkg.sv
// Shared TileLink-UL constants and the response bundle
// used by the SRAM responder.
package tl_pkg;

  localparam int SRC_W  = 5;
  localparam int ADDR_W = 31;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    REQ_GET,
    REQ_PUT,
    REQ_BAD
  } req_kind_e;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
    logic             denied;
    logic             corrupt;
    logic             has_data;
  } resp_t;

  function automatic req_kind_e classify(logic [2:0] op);
    req_kind_e k;
    k = REQ_BAD;
    if (op == GET)
      k = REQ_GET;
    else if (op == PUT_FULL || op == PUT_PARTIAL)
      k = REQ_PUT;
    return k;
  endfunction

endpackage

// File: rtl/tl_sram_responder_if.sv
// A/D channel bundle between a TileLink-UL requester
// and the SRAM responder.
interface tl_sram_responder_if;
  import tl_pkg::*;

  logic              a_ready;
  logic              a_valid;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [MASK_W-1:0] a_mask;
  logic [DATA_W-1:0] a_data;
  logic              a_corrupt;

  logic              d_ready;
  logic              d_valid;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_sink;
  logic              d_denied;
  logic [DATA_W-1:0] d_data;
  logic              d_corrupt;

  modport master (
    input  a_ready,
    output a_valid, a_opcode, a_param, a_size,
    output a_source, a_address, a_mask, a_data,
    output a_corrupt,
    output d_ready,
    input  d_valid, d_opcode, d_param, d_size,
    input  d_source, d_sink, d_denied, d_data,
    input  d_corrupt
  );

  modport slave (
    output a_ready,
    input  a_valid, a_opcode, a_param, a_size,
    input  a_source, a_address, a_mask, a_data,
    input  a_corrupt,
    input  d_ready,
    output d_valid, d_opcode, d_param, d_size,
    output d_source, d_sink, d_denied, d_data,
    output d_corrupt
  );

endinterface

// File: rtl/tl_resp_mem.sv
// Word-addressed SRAM, byte-lane write enables,
// synchronous write and registered read.
module tl_resp_mem
  import tl_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [MASK_W-1:0] be_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (be_i[i])
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i)
      rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tl_sram_responder.sv
// TileLink-UL manager terminating an A/D port onto a
// byte-masked SRAM; single beat, one response in flight.
module tl_sram_responder
  import tl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE    = 31'h0800_0000,
  parameter int                DEPTH   = 256,
  parameter logic              SINK_ID = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              auto_in_a_ready,
  input  logic              auto_in_a_valid,
  input  logic [2:0]        auto_in_a_bits_opcode,
  input  logic [2:0]        auto_in_a_bits_param,
  input  logic [2:0]        auto_in_a_bits_size,
  input  logic [SRC_W-1:0]  auto_in_a_bits_source,
  input  logic [ADDR_W-1:0] auto_in_a_bits_address,
  input  logic [MASK_W-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0] auto_in_a_bits_data,
  input  logic              auto_in_a_bits_corrupt,
  input  logic              auto_in_d_ready,
  output logic              auto_in_d_valid,
  output logic [2:0]        auto_in_d_bits_opcode,
  output logic [1:0]        auto_in_d_bits_param,
  output logic [2:0]        auto_in_d_bits_size,
  output logic [SRC_W-1:0]  auto_in_d_bits_source,
  output logic              auto_in_d_bits_sink,
  output logic              auto_in_d_bits_denied,
  output logic [DATA_W-1:0] auto_in_d_bits_data,
  output logic              auto_in_d_bits_corrupt
);

  localparam int IDX_W = $clog2(DEPTH);

  logic              d_valid_q, d_valid_d;
  resp_t             resp_q, resp_d;
  logic              a_fire, d_fire;
  logic [ADDR_W-1:0] offset;
  logic              in_range, legal;
  logic [IDX_W-1:0]  idx;
  req_kind_e         kind;
  logic              we, re;
  logic [DATA_W-1:0] rdata;
  logic              unused_bits;

  assign auto_in_a_ready = !d_valid_q || auto_in_d_ready;
  assign a_fire = auto_in_a_valid && auto_in_a_ready;
  assign d_fire = d_valid_q && auto_in_d_ready;

  assign offset   = auto_in_a_bits_address - BASE;
  assign in_range = (auto_in_a_bits_address >= BASE)
                 && (offset[ADDR_W-1:3] < 28'(DEPTH));
  assign idx      = offset[IDX_W+2:3];
  assign kind     = classify(auto_in_a_bits_opcode);
  assign legal    = in_range
                 && (auto_in_a_bits_size <= 3'd3)
                 && (kind != REQ_BAD);

  always_comb begin
    resp_d        = resp_q;
    we            = 1'b0;
    re            = 1'b0;
    if (a_fire) begin
      resp_d.size     = auto_in_a_bits_size;
      resp_d.source   = auto_in_a_bits_source;
      resp_d.opcode   = ACCESS_ACK;
      resp_d.denied   = !legal;
      resp_d.corrupt  = 1'b0;
      resp_d.has_data = 1'b0;
      unique case (1'b1)
        kind == REQ_GET: begin
          resp_d.opcode   = ACCESS_ACK_DATA;
          resp_d.corrupt  = !legal;
          resp_d.has_data = legal;
          re              = legal;
        end
        kind == REQ_PUT: begin
          // Poisoned write data is refused outright.
          resp_d.denied = !legal || auto_in_a_bits_corrupt;
          we = legal && !auto_in_a_bits_corrupt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    d_valid_d = d_valid_q;
    if (a_fire)
      d_valid_d = 1'b1;
    else if (d_fire)
      d_valid_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_valid_q <= 1'b0;
      resp_q    <= '0;
    end else begin
      d_valid_q <= d_valid_d;
      resp_q    <= resp_d;
    end
  end

  tl_resp_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (we),
    .be_i    (auto_in_a_bits_mask),
    .re_i    (re),
    .addr_i  (idx),
    .wdata_i (auto_in_a_bits_data),
    .rdata_o (rdata)
  );

  assign auto_in_d_valid        = d_valid_q;
  assign auto_in_d_bits_opcode  = resp_q.opcode;
  assign auto_in_d_bits_param   = 2'd0;
  assign auto_in_d_bits_size    = resp_q.size;
  assign auto_in_d_bits_source  = resp_q.source;
  assign auto_in_d_bits_sink    = SINK_ID;
  assign auto_in_d_bits_denied  = resp_q.denied;
  assign auto_in_d_bits_corrupt = resp_q.corrupt;
  assign auto_in_d_bits_data    = resp_q.has_data ? rdata : '0;

  assign unused_bits = ^{auto_in_a_bits_param, offset[2:0]};

endmodule

// File: doc/tl_sram_responder.md
Name: tl_sram_responder

Overview:
- TileLink-UL manager (responder) terminating an A/D port: accepts A-channel Get/PutFullData/PutPartialData and returns D-channel AccessAck/AccessAckData.
- Sits downstream of the FIFO-fixer/crossbar path as the slave end of the same auto_in A/D interface.
- Backs a word-addressed, byte-masked SRAM of DEPTH 64-bit words starting at BASE.
- Single-beat only, one response in flight, responses in request order.

Parameters:
- BASE, 31'h0800_0000, byte base address of the window.
- DEPTH, 256, number of 64-bit words (power of two, 2..4096).
- SINK_ID, 0, constant value driven on d_bits_sink.

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- auto_in_a_ready  out  1  A accept
- auto_in_a_valid  in  1  A request valid
- auto_in_a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get, others unsupported
- auto_in_a_bits_param  in  3  ignored
- auto_in_a_bits_size  in  3  log2 bytes
- auto_in_a_bits_source  in  5  requester ID
- auto_in_a_bits_address  in  31  byte address
- auto_in_a_bits_mask  in  8  byte lanes
- auto_in_a_bits_data  in  64  write data
- auto_in_a_bits_corrupt  in  1  write data poisoned
- auto_in_d_ready  in  1  D accept
- auto_in_d_valid  out  1  D response valid
- auto_in_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData
- auto_in_d_bits_param  out  2  always 0
- auto_in_d_bits_size  out  3  echo of a.size
- auto_in_d_bits_source  out  5  echo of a.source
- auto_in_d_bits_sink  out  1  SINK_ID
- auto_in_d_bits_denied  out  1  request refused
- auto_in_d_bits_data  out  64  read data
- auto_in_d_bits_corrupt  out  1  data invalid

Behaviour:
- Reset (reset=0, async): d_valid=0; all d_bits registers 0. SRAM contents are not reset. a_ready is combinational, so it is 1 out of reset.
- a_ready = !d_valid || d_ready. This is a one-entry response register with same-cycle drain/refill, so it sustains one request per cycle.
- A fire (a_valid && a_ready) at edge N: response registered; d_valid=1 from cycle N+1 (latency 1). d_valid holds and d_bits stay stable until d_ready.
- D fire without A fire: d_valid goes to 0 on the next edge. Both fire in the same cycle: d_valid stays 1 and the new response is loaded.
- In range: BASE <= address < BASE+8*DEPTH. Index = (address-BASE)>>3.
- Legal: in range && size<=3 && opcode in {0,1,4}. Otherwise denied=1, and no SRAM write occurs.
- Get: opcode=1 (AccessAckData).
  - Legal: data = SRAM word at index, read at fire edge N. Because the write occurs on an earlier edge, a Get at N+1 after a Put at N returns the new data.
  - Denied: data=0, corrupt=1.
- PutFull/PutPartial: opcode=0 (AccessAck), data=0, corrupt=0.
  - Write lanes where mask[i]=1.
  - If a_corrupt=1: write suppressed, denied=1.
- Unsupported opcode (2,3,5,6,7): opcode=0, denied=1.
- Mask/address alignment is not checked. The mask is used as given.
- Only one A accepted per cycle, so there is no read/write port conflict. SRAM is a single port with synchronous write.
- Reset asserted mid-response: d_valid drops immediately, and the pending response is lost.

Decomposition:
- Shared package tl_pkg:
  - opcode constants: PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1
  - field widths: source 5, address 31, data 64, mask 8
- Sub-module tl_resp_mem: DEPTH x 64 SRAM with 8-lane byte-write enable, synchronous write, registered read.
- Top module holds decode, the response register and the ready logic.

Test Plan:
- Reset, then Put to BASE with data 64'h1122_3344_5566_7788, mask 8'hFF, source 3 -> next cycle d_valid=1, opcode 0, source 3, denied 0. Then Get BASE, size 3 -> opcode 1, data 64'h1122_3344_5566_7788.
- PutPartial to BASE with mask 8'h0F, data 64'hFFFF_FFFF_AAAA_BBBB, then Get BASE -> data 64'h1122_3344_AAAA_BBBB.
- Get at BASE+8*DEPTH, and PutFull with corrupt=1 at BASE -> both denied=1; the Get has corrupt=1, data 0. A following Get BASE returns unchanged data.
- Opcode 2 (Arithmetic) at BASE, source 7 -> opcode 0, denied 1, source 7, memory unchanged.
- Back-to-back: 8 Gets with d_ready=1 throughout -> a_ready stays 1, 8 responses on consecutive cycles in order.
- Backpressure: d_ready=0 for 5 cycles while a_valid=1 -> a_ready=0, d_bits stable. Then release -> one D fire and a new A fire in the same cycle. Assert reset mid-wait -> d_valid=0 asynchronously.
